// File: rtl/memory_stage.sv
// Memory stage: issues data-memory loads/stores over a req/ack port,
// stalls upstream while waiting, and owns the MEM/WB pipeline register.
module memory_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_m,
    input  logic [15:0] aluOut_m,
    input  logic [15:0] read2Data_m,
    input  logic [15:0] pcInc_m,
    input  logic [2:0]  writeReg_m,
    input  logic        regWrite_m,
    input  logic        memRead_m,
    input  logic        memWrite_m,
    input  logic        memToReg_m,
    input  logic        link_m,
    input  logic        halt_m,

    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,

    output logic        stall_m,
    output logic        err,

    output logic        valid_w,
    output logic        regWrite_w,
    output logic        memToReg_w,
    output logic        link_w,
    output logic        halt_w,
    output logic [15:0] memData_w,
    output logic [15:0] aluOut_w,
    output logic [15:0] pcInc_w,
    output logic [2:0]  writeReg_w
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        HALTED = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LIMIT = 8'(TIMEOUT);

    state_t     state;
    state_t     state_nx;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;
    logic       err_nx;

    logic       acc;
    logic       hlt;
    logic       is_rd;
    logic       is_wr;
    logic       req;
    logic       ld_instr;
    logic       ld_bubble;
    logic       ld_fault;

    // Address and store data come straight from the EX/MEM latch.
    assign mem_addr  = aluOut_m;
    assign mem_wdata = read2Data_m;

    // Decode the slot: write wins when both access bits are set.
    always_comb begin
        acc   = valid_m & (memRead_m | memWrite_m);
        hlt   = valid_m & halt_m;
        is_wr = memWrite_m;
        is_rd = memRead_m & ~memWrite_m;
    end

    // Next-state, stall and MEM/WB load selection.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        err_nx    = err;
        req       = 1'b0;
        stall_m   = 1'b0;
        ld_instr  = 1'b0;
        ld_bubble = 1'b0;
        ld_fault  = 1'b0;
        unique case (state)
            IDLE: begin
                if (hlt) begin
                    ld_instr = 1'b1;
                    state_nx = HALTED;
                end else if (!valid_m) begin
                    ld_bubble = 1'b1;
                end else if (acc) begin
                    req = 1'b1;
                    if (mem_ack) begin
                        ld_instr = 1'b1;
                    end else begin
                        stall_m   = 1'b1;
                        ld_bubble = 1'b1;
                        state_nx  = WAIT;
                        cnt_nx    = 8'd1;
                    end
                end else begin
                    ld_instr = 1'b1;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (mem_ack) begin
                    ld_instr = 1'b1;
                    state_nx = IDLE;
                    cnt_nx   = 8'd0;
                end else if (cnt == CNT_LIMIT) begin
                    stall_m  = 1'b1;
                    ld_fault = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = ERR;
                    cnt_nx   = 8'd0;
                end else begin
                    stall_m   = 1'b1;
                    ld_bubble = 1'b1;
                    cnt_nx    = cnt + 8'd1;
                end
            end
            HALTED, ERR: begin
                stall_m   = 1'b1;
                ld_bubble = 1'b1;
            end
        endcase
    end

    // Requests are masked during reset so an aborted access drops at once.
    always_comb begin
        mem_rd = rst & req & is_rd;
        mem_wr = rst & req & is_wr;
    end

    // State, wait counter and sticky error.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err   <= err_nx;
        end
    end

    // MEM/WB register: instruction, bubble or timeout-halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_w    <= 1'b0;
            regWrite_w <= 1'b0;
            memToReg_w <= 1'b0;
            link_w     <= 1'b0;
            halt_w     <= 1'b0;
            memData_w  <= 16'd0;
            aluOut_w   <= 16'd0;
            pcInc_w    <= 16'd0;
            writeReg_w <= 3'd0;
        end else if (ld_instr) begin
            valid_w    <= valid_m;
            regWrite_w <= regWrite_m;
            memToReg_w <= memToReg_m;
            link_w     <= link_m;
            halt_w     <= halt_m;
            aluOut_w   <= aluOut_m;
            pcInc_w    <= pcInc_m;
            writeReg_w <= writeReg_m;
            if (acc && is_rd) begin
                memData_w <= mem_rdata;
            end
        end else if (ld_fault) begin
            valid_w    <= 1'b1;
            regWrite_w <= 1'b0;
            halt_w     <= 1'b1;
        end else if (ld_bubble) begin
            valid_w    <= 1'b0;
            regWrite_w <= 1'b0;
            halt_w     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus randomized
// instruction stream checked against a transaction-level model.
module tb_memory_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_m;
    logic [15:0] aluOut_m;
    logic [15:0] read2Data_m;
    logic [15:0] pcInc_m;
    logic [2:0]  writeReg_m;
    logic        regWrite_m;
    logic        memRead_m;
    logic        memWrite_m;
    logic        memToReg_m;
    logic        link_m;
    logic        halt_m;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall_m;
    logic        err;
    logic        valid_w;
    logic        regWrite_w;
    logic        memToReg_w;
    logic        link_w;
    logic        halt_w;
    logic [15:0] memData_w;
    logic [15:0] aluOut_w;
    logic [15:0] pcInc_w;
    logic [2:0]  writeReg_w;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_md;
    bit          md_known;

    always #5 clk = ~clk;

    memory_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .valid_m(valid_m), .aluOut_m(aluOut_m),
        .read2Data_m(read2Data_m), .pcInc_m(pcInc_m),
        .writeReg_m(writeReg_m), .regWrite_m(regWrite_m),
        .memRead_m(memRead_m), .memWrite_m(memWrite_m),
        .memToReg_m(memToReg_m), .link_m(link_m), .halt_m(halt_m),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_m(stall_m), .err(err),
        .valid_w(valid_w), .regWrite_w(regWrite_w),
        .memToReg_w(memToReg_w), .link_w(link_w), .halt_w(halt_w),
        .memData_w(memData_w), .aluOut_w(aluOut_w),
        .pcInc_w(pcInc_w), .writeReg_w(writeReg_w)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        valid_m     = 1'b0;
        aluOut_m    = 16'd0;
        read2Data_m = 16'd0;
        pcInc_m     = 16'd0;
        writeReg_m  = 3'd0;
        regWrite_m  = 1'b0;
        memRead_m   = 1'b0;
        memWrite_m  = 1'b0;
        memToReg_m  = 1'b0;
        link_m      = 1'b0;
        halt_m      = 1'b0;
        mem_rdata   = 16'd0;
        mem_ack     = 1'b0;
    endtask

    task automatic chk_w_zero(input string tag);
        chk({tag, "_valid_w"}, valid_w, 0);
        chk({tag, "_regWrite_w"}, regWrite_w, 0);
        chk({tag, "_memToReg_w"}, memToReg_w, 0);
        chk({tag, "_link_w"}, link_w, 0);
        chk({tag, "_halt_w"}, halt_w, 0);
        chk({tag, "_memData_w"}, memData_w, 0);
        chk({tag, "_aluOut_w"}, aluOut_w, 0);
        chk({tag, "_pcInc_w"}, pcInc_w, 0);
        chk({tag, "_writeReg_w"}, writeReg_w, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_in();
        tick();
        chk_w_zero("reset");
        rst = 1'b1;
        exp_md   = 16'd0;
        md_known = 1'b1;
    endtask

    // One instruction through M: an access acked on request cycle k
    // takes k cycles with k-1 stalls and k-1 bubbles ahead of it.
    task automatic run_instr(input logic v, input logic rd, input logic wr,
                             input logic rw, input logic m2r, input logic lk,
                             input logic [2:0] wreg, input logic [15:0] alu,
                             input logic [15:0] r2, input logic [15:0] pc,
                             input logic [15:0] rdata, input int k);
        bit access;
        bit rd_only;
        int n;
        access  = v & (rd | wr);
        rd_only = rd & ~wr;
        n       = access ? k : 1;
        valid_m     = v;
        memRead_m   = rd;
        memWrite_m  = wr;
        regWrite_m  = rw;
        memToReg_m  = m2r;
        link_m      = lk;
        halt_m      = 1'b0;
        writeReg_m  = wreg;
        aluOut_m    = alu;
        read2Data_m = r2;
        pcInc_m     = pc;
        for (int c = 1; c <= n; c++) begin
            mem_ack   = access ? (c == n) : 1'($urandom_range(0, 1));
            mem_rdata = (c == n) ? rdata : 16'($urandom);
            #3;
            chk("mem_rd", mem_rd, access & rd_only);
            chk("mem_wr", mem_wr, access & wr);
            chk("stall_m", stall_m, c < n);
            chk("mem_addr", mem_addr, alu);
            chk("mem_wdata", mem_wdata, r2);
            tick();
            if (c < n || !v) begin
                chk("bub_valid_w", valid_w, 0);
                chk("bub_regWrite_w", regWrite_w, 0);
                chk("bub_halt_w", halt_w, 0);
                md_known = 1'b0;
            end else begin
                chk("valid_w", valid_w, 1);
                chk("regWrite_w", regWrite_w, rw);
                chk("memToReg_w", memToReg_w, m2r);
                chk("link_w", link_w, lk);
                chk("halt_w", halt_w, 0);
                chk("writeReg_w", writeReg_w, wreg);
                chk("aluOut_w", aluOut_w, alu);
                chk("pcInc_w", pcInc_w, pc);
                if (access && rd_only) begin
                    exp_md   = rdata;
                    md_known = 1'b1;
                end
                if (md_known) chk("memData_w", memData_w, exp_md);
            end
        end
        mem_ack = 1'b0;
    endtask

    initial begin
        clear_in();
        rst = 1'b0;
        tick();
        chk_w_zero("por");
        valid_m   = 1'b1;
        memRead_m = 1'b1;
        #3;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        tick();
        rst = 1'b1;
        clear_in();
        exp_md   = 16'd0;
        md_known = 1'b1;

        run_instr(1, 0, 0, 1, 0, 0, 3'd5, 16'h1234, 16'h0, 16'h0010,
                  16'h0, 1);
        run_instr(1, 1, 0, 1, 1, 0, 3'd2, 16'h0040, 16'h0, 16'h0012,
                  16'hBEEF, 1);
        run_instr(1, 0, 1, 0, 0, 0, 3'd0, 16'h0080, 16'h00A5, 16'h0014,
                  16'h0, 3);
        run_instr(1, 1, 0, 1, 1, 0, 3'd3, 16'h0100, 16'h0, 16'h0016,
                  16'hCAFE, TO + 1);

        for (int i = 0; i < 60; i++) begin
            logic v;
            int   kind;
            v    = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 3);
            run_instr(v, kind == 1 || kind == 3, kind == 2 || kind == 3,
                      1'($urandom), 1'($urandom), 1'($urandom),
                      3'($urandom), 16'($urandom), 16'($urandom),
                      16'($urandom), 16'($urandom),
                      $urandom_range(1, TO + 1));
        end

        run_instr(1, 0, 0, 1, 0, 0, 3'd1, 16'h1111, 16'h0, 16'h0020,
                  16'h0, 1);
        run_instr(1, 0, 0, 1, 0, 0, 3'd2, 16'h2222, 16'h0, 16'h0022,
                  16'h0, 1);
        valid_m    = 1'b1;
        halt_m     = 1'b1;
        regWrite_m = 1'b0;
        aluOut_m   = 16'h3333;
        #3;
        chk("halt_stall", stall_m, 0);
        chk("halt_mem_rd", mem_rd, 0);
        tick();
        chk("halt_halt_w", halt_w, 1);
        chk("halt_valid_w", valid_w, 1);
        chk("halt_aluOut_w", aluOut_w, 16'h3333);
        halt_m    = 1'b0;
        memRead_m = 1'b1;
        mem_ack   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #3;
            chk("halted_stall", stall_m, 1);
            chk("halted_mem_rd", mem_rd, 0);
            tick();
            chk("halted_halt_w", halt_w, 0);
            chk("halted_valid_w", valid_w, 0);
        end
        do_reset();

        valid_m    = 1'b1;
        memRead_m  = 1'b1;
        regWrite_m = 1'b1;
        aluOut_m   = 16'h0200;
        for (int c = 1; c <= TO + 1; c++) begin
            #3;
            chk("to_mem_rd", mem_rd, 1);
            chk("to_stall", stall_m, 1);
            tick();
            if (c <= TO) begin
                chk("to_wait_valid_w", valid_w, 0);
                chk("to_wait_err", err, 0);
            end else begin
                chk("to_err", err, 1);
                chk("to_valid_w", valid_w, 1);
                chk("to_halt_w", halt_w, 1);
                chk("to_regWrite_w", regWrite_w, 0);
            end
        end
        mem_ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk("err_mem_rd", mem_rd, 0);
            chk("err_stall", stall_m, 1);
            tick();
            chk("err_halt_w", halt_w, 0);
            chk("err_valid_w", valid_w, 0);
            chk("err_sticky", err, 1);
        end
        do_reset();

        run_instr(1, 0, 0, 1, 0, 1, 3'd7, 16'h4444, 16'h0, 16'h0030,
                  16'h0, 1);
        valid_m   = 1'b1;
        memRead_m = 1'b1;
        aluOut_m  = 16'h0300;
        #3;
        chk("mid_req", mem_rd, 1);
        tick();
        rst     = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 16'h5A5A;
        #3;
        chk("mid_rst_mem_rd", mem_rd, 0);
        tick();
        chk_w_zero("mid_rst");
        rst = 1'b1;
        clear_in();
        exp_md   = 16'd0;
        md_known = 1'b1;
        run_instr(1, 1, 0, 1, 1, 0, 3'd4, 16'h0302, 16'h0, 16'h0040,
                  16'h1357, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
